// File: rtl/dab_pwm_modulator.sv
// dab_pwm_modulator -- four-leg phase-shift PWM for a dual-active-bridge stage.
// A 9-bit carrier (512 counts per switching period) advances on a programmable
// prescaler tick. tau1/tau2/phi are double-buffered and applied only at period
// start (wrap or enable start), so a period never mixes old and new settings.
// Build option: define DAB_PWM_DEADTIME_EN to insert DEAD_CYCLES clk of
// all-low dead time on every leg transition; without it the gates follow the
// leg references directly and DEAD_CYCLES only gets a range check.
module dab_pwm_modulator #(
  parameter int DEAD_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic signed [8:0] tau1,
  input  logic signed [8:0] tau2,
  input  logic signed [8:0] phi,
  input  logic              param_valid,
  input  logic [15:0]       tick_div,
  output logic [3:0]        gate_hi,
  output logic [3:0]        gate_lo,
  output logic              trigger_out
);

  if (DEAD_CYCLES < 1 || DEAD_CYCLES > 255) begin : g_dead_range
    $error("DEAD_CYCLES must be in 1..255");
  end

  logic        run;
  logic [8:0]  cnt;
  logic [15:0] pre;
  logic [15:0] act_div;
  logic [8:0]  pend_tau1, pend_tau2, pend_phi;
  logic [8:0]  act_tau1, act_tau2, act_phi;

  logic        start, tick, wrap, load;
  logic [8:0]  src_tau1, src_tau2, src_phi;
  logic [8:0]  new_tau1, new_tau2;
  logic [3:0][8:0] off;
  logic [3:0]  leg_ref;

  // True when carrier count c lies in the 256-count window starting at o (mod 512).
  function automatic logic in_window(input logic [8:0] c, input logic [8:0] o);
    logic [8:0] d;
    d = c - o;
    return ~d[8];
  endfunction

  assign start = en && !run;
  assign tick  = en && run && (pre == act_div);
  assign wrap  = tick && (cnt == 9'd511);
  assign load  = start || wrap;

  // A strobe landing on the load cycle goes straight to the active set.
  assign src_tau1 = param_valid ? tau1 : pend_tau1;
  assign src_tau2 = param_valid ? tau2 : pend_tau2;
  assign src_phi  = param_valid ? phi  : pend_phi;
  assign new_tau1 = src_tau1[8] ? 9'd0 : src_tau1;
  assign new_tau2 = src_tau2[8] ? 9'd0 : src_tau2;

  assign off[0] = 9'd0;
  assign off[1] = act_tau1;
  assign off[2] = act_phi;
  assign off[3] = act_phi + act_tau2;

  // Leg references from the current carrier count and active offsets.
  always_comb begin
    leg_ref = '0;
    for (int i = 0; i < 4; i++) begin
      leg_ref[i] = in_window(cnt, off[i]);
    end
  end

  // Parameter capture, period-boundary load, prescaler, carrier and trigger.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run         <= 1'b0;
      cnt         <= '0;
      pre         <= '0;
      act_div     <= '0;
      pend_tau1   <= '0;
      pend_tau2   <= '0;
      pend_phi    <= '0;
      act_tau1    <= '0;
      act_tau2    <= '0;
      act_phi     <= '0;
      trigger_out <= 1'b0;
    end else begin
      if (param_valid) begin
        pend_tau1 <= tau1;
        pend_tau2 <= tau2;
        pend_phi  <= phi;
      end
      if (load) begin
        act_tau1 <= new_tau1;
        act_tau2 <= new_tau2;
        act_phi  <= src_phi;
        act_div  <= tick_div;
      end
      if (!en) begin
        run         <= 1'b0;
        cnt         <= '0;
        pre         <= '0;
        trigger_out <= 1'b0;
      end else if (start) begin
        run         <= 1'b1;
        cnt         <= '0;
        pre         <= '0;
        trigger_out <= 1'b1;
      end else begin
        trigger_out <= wrap;
        if (tick) begin
          pre <= '0;
          cnt <= cnt + 9'd1;
        end else begin
          pre <= pre + 16'd1;
        end
      end
    end
  end

`ifdef DAB_PWM_DEADTIME_EN
  localparam logic [7:0] DT_LOAD = 8'(DEAD_CYCLES - 1);

  logic [3:0]      ref_prev;
  logic [3:0][7:0] dt_cnt;
  logic [3:0]      start_ref;

  // References at count 0 under the values being loaded, so the start-up dead
  // time is not mistaken for a second transition one clk later.
  assign start_ref[0] = in_window(9'd0, 9'd0);
  assign start_ref[1] = in_window(9'd0, new_tau1);
  assign start_ref[2] = in_window(9'd0, src_phi);
  assign start_ref[3] = in_window(9'd0, src_phi + new_tau2);

  // Per-leg dead-time insertion; any reference change restarts the window.
  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      ref_prev <= '0;
      dt_cnt   <= '0;
      gate_hi  <= '0;
      gate_lo  <= '0;
    end else if (start) begin
      ref_prev <= start_ref;
      dt_cnt   <= {4{DT_LOAD}};
      gate_hi  <= '0;
      gate_lo  <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (leg_ref[i] != ref_prev[i]) begin
          ref_prev[i] <= leg_ref[i];
          dt_cnt[i]   <= DT_LOAD;
          gate_hi[i]  <= 1'b0;
          gate_lo[i]  <= 1'b0;
        end else if (dt_cnt[i] != 8'd0) begin
          dt_cnt[i]   <= dt_cnt[i] - 8'd1;
          gate_hi[i]  <= 1'b0;
          gate_lo[i]  <= 1'b0;
        end else begin
          gate_hi[i]  <= leg_ref[i];
          gate_lo[i]  <= ~leg_ref[i];
        end
      end
    end
  end
`else
  // Gates follow the references directly, one clk behind the carrier.
  always_ff @(posedge clk) begin
    if (!rst_n || !en || start) begin
      gate_hi <= '0;
      gate_lo <= '0;
    end else begin
      gate_hi <= leg_ref;
      gate_lo <= ~leg_ref;
    end
  end
`endif

endmodule
